adder_byte_bridge: RTL and testbench



---
 rtl/adder_pkg.sv | 18 +
 rtl/adder_tx_serializer.sv | 50 +++++
 rtl/adder_byte_bridge.sv | 115 +++++++++++
 tb/tb_adder_byte_bridge.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder host bridge: state encoding, byte width
// and operand byte-count helper.
package adder_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    RECV_A  = 2'd0,
    RECV_B  = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } state_t;

  function automatic int unsigned calc_bytes(input int unsigned width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/adder_tx_serializer.sv
// Loads a WIDTH-bit result word and emits it LSB byte first over valid/ready.
// done_c flags the handshake of the final byte.
module adder_tx_serializer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  output logic             done_c
);
  import adder_pkg::*;

  localparam int unsigned BYTES = calc_bytes(WIDTH);
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_nxt;
  logic [CNT_W-1:0] cnt_q;

  assign word_nxt = word_q >> BYTE_W;
  assign done_c   = tx_valid && tx_ready && (cnt_q == CNT_W'(BYTES - 1));

  // Result register doubles as the shift register feeding tx_data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      word_q   <= '0;
      cnt_q    <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (load) begin
      word_q   <= word;
      cnt_q    <= '0;
      tx_valid <= 1'b1;
      tx_data  <= word[BYTE_W-1:0];
    end else if (tx_valid && tx_ready) begin
      if (done_c) begin
        tx_valid <= 1'b0;
      end else begin
        word_q  <= word_nxt;
        cnt_q   <= cnt_q + CNT_W'(1);
        tx_data <= word_nxt[BYTE_W-1:0];
      end
    end
  end

endmodule

// File: rtl/adder_byte_bridge.sv
// Host byte-stream bridge: assembles two little-endian operands for the adder
// core, captures its one-cycle sum and returns it as a byte stream.
module adder_byte_bridge #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             add_en,
  output logic [WIDTH-1:0] add_x,
  input  logic [WIDTH-1:0] add_out
);
  import adder_pkg::*;

  localparam int unsigned BYTES = calc_bytes(WIDTH);
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [WIDTH-1:0] add_x_d;
  logic             add_en_d;
  logic             rx_ready_d;
  logic             wait_q, wait_d;
  logic             load_c;
  logic             done_c;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= RECV_A;
      cnt_q    <= '0;
      asm_q    <= '0;
      add_x    <= '0;
      add_en   <= 1'b0;
      rx_ready <= 1'b1;
      wait_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
      add_x    <= add_x_d;
      add_en   <= add_en_d;
      rx_ready <= rx_ready_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    add_x_d    = add_x;
    add_en_d   = 1'b0;
    rx_ready_d = rx_ready;
    wait_d     = wait_q;
    load_c     = 1'b0;

    case (state_q)
      RECV_A, RECV_B: begin
        if (rx_valid && rx_ready) begin
          for (int k = 0; k < int'(BYTES); k++) begin
            if (cnt_q == CNT_W'(k)) asm_d[k*BYTE_W +: BYTE_W] = rx_data;
          end
          if (cnt_q == CNT_W'(BYTES - 1)) begin
            add_x_d  = asm_d;
            add_en_d = 1'b1;
            cnt_d    = '0;
            if (state_q == RECV_A) begin
              state_d = RECV_B;
            end else begin
              state_d    = CAPTURE;
              rx_ready_d = 1'b0;
              wait_d     = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      // First cycle overlaps add_en for B; the sum is present on the second.
      CAPTURE: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else begin
          load_c  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (done_c) begin
          state_d    = RECV_A;
          rx_ready_d = 1'b1;
        end
      end
      default: state_d = RECV_A;
    endcase
  end

  adder_tx_serializer #(.WIDTH(WIDTH)) u_tx (
    .clk      (clk),
    .resetn   (resetn),
    .load     (load_c),
    .word     (add_out),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .done_c   (done_c)
  );

endmodule

// File: tb/tb_adder_byte_bridge.sv
// Scoreboard bench for adder_byte_bridge at WIDTH=32 and WIDTH=8, with a
// behavioural adder core honouring the one-cycle sum contract.
module tb_adder_byte_bridge;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=32 instance
  logic        rx_valid32, rx_ready32, tx_valid32, tx_ready32, add_en32;
  logic [7:0]  rx_data32, tx_data32;
  logic [31:0] add_x32, add_out32;
  // WIDTH=8 instance
  logic        rx_valid8, rx_ready8, tx_valid8, tx_ready8, add_en8;
  logic [7:0]  rx_data8, tx_data8, add_x8, add_out8;

  adder_byte_bridge #(.WIDTH(32)) u32 (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid32), .rx_data(rx_data32),
    .rx_ready(rx_ready32), .tx_valid(tx_valid32), .tx_data(tx_data32),
    .tx_ready(tx_ready32), .add_en(add_en32), .add_x(add_x32), .add_out(add_out32)
  );

  adder_byte_bridge #(.WIDTH(8)) u8 (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid8), .rx_data(rx_data8),
    .rx_ready(rx_ready8), .tx_valid(tx_valid8), .tx_data(tx_data8),
    .tx_ready(tx_ready8), .add_en(add_en8), .add_x(add_x8), .add_out(add_out8)
  );

  // Adder core models: first en latches A, second en drives A+B for one cycle.
  logic        have_a32, have_a8;
  logic [31:0] a32;
  logic [7:0]  a8;

  always @(posedge clk) begin
    if (!resetn) begin
      have_a32 <= 1'b0; a32 <= '0; add_out32 <= '0;
    end else begin
      add_out32 <= '0;
      if (add_en32) begin
        if (!have_a32) begin a32 <= add_x32; have_a32 <= 1'b1; end
        else begin add_out32 <= a32 + add_x32; have_a32 <= 1'b0; end
      end
    end
  end

  always @(posedge clk) begin
    if (!resetn) begin
      have_a8 <= 1'b0; a8 <= '0; add_out8 <= '0;
    end else begin
      add_out8 <= '0;
      if (add_en8) begin
        if (!have_a8) begin a8 <= add_x8; have_a8 <= 1'b1; end
        else begin add_out8 <= a8 + add_x8; have_a8 <= 1'b0; end
      end
    end
  end

  logic [31:0] exp_en32[$];
  logic [7:0]  exp_tx32[$];
  logic [7:0]  exp_en8[$];
  logic [7:0]  exp_tx8[$];
  int          en_cnt32 = 0;
  bit          b2b8 = 1'b0;
  bit          bp_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the 32-bit instance.
  initial begin : mon32
    bit         stalled = 1'b0;
    logic [7:0] held = 8'h00;
    logic [31:0] ev;
    logic [7:0]  eb;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        stalled = 1'b0;
      end else begin
        if (add_en32) begin
          en_cnt32++;
          if (exp_en32.size() == 0) chk("unexpected_add_en32", add_x32, 32'hxxxx_xxxx);
          else begin ev = exp_en32.pop_front(); chk("add_x32", add_x32, ev); end
        end
        if (tx_valid32 && tx_ready32) begin
          if (exp_tx32.size() == 0) chk("unexpected_tx32", 32'(tx_data32), 32'hxxxx_xxxx);
          else begin eb = exp_tx32.pop_front(); chk("tx_data32", 32'(tx_data32), 32'(eb)); end
        end
        if (tx_valid32) chk("rx_ready_low_during_tx", 32'(rx_ready32), 32'd0);
        if (stalled) begin
          chk("tx_valid_held", 32'(tx_valid32), 32'd1);
          chk("tx_data_held", 32'(tx_data32), 32'(held));
        end
        stalled = tx_valid32 && !tx_ready32;
        held    = tx_data32;
      end
    end
  end

  // Monitor for the 8-bit instance.
  initial begin : mon8
    bit         prev_en = 1'b0;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_en = 1'b0;
      end else begin
        if (add_en8) begin
          if (prev_en) b2b8 = 1'b1;
          if (exp_en8.size() == 0) chk("unexpected_add_en8", 32'(add_x8), 32'hxxxx_xxxx);
          else begin eb = exp_en8.pop_front(); chk("add_x8", 32'(add_x8), 32'(eb)); end
        end
        if (tx_valid8 && tx_ready8) begin
          if (exp_tx8.size() == 0) chk("unexpected_tx8", 32'(tx_data8), 32'hxxxx_xxxx);
          else begin eb = exp_tx8.pop_front(); chk("tx_data8", 32'(tx_data8), 32'(eb)); end
        end
        prev_en = add_en8;
      end
    end
  end

  // tx_ready driver: optional 5-cycle stall on every byte of the 32-bit link.
  initial begin : txdrv
    int stall = 0;
    tx_ready32 = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode && tx_valid32 && stall < 5) begin
        tx_ready32 = 1'b0;
        stall++;
      end else begin
        tx_ready32 = 1'b1;
        stall = 0;
      end
    end
  end

  // Each send task starts just after a posedge and returns just after the
  // posedge at which the byte was accepted.
  task automatic send32(input logic [7:0] b, input bit gaps);
    bit seen;
    bit ok = 1'b0;
    if (gaps) begin
      rx_valid32 = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rx_valid32 = 1'b1;
    rx_data32  = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); seen = rx_ready32;
      @(posedge clk); #1;
      ok = seen;
    end
    if (!ok) chk("rx_accept_timeout32", 32'd0, 32'd1);
  endtask

  task automatic send8(input logic [7:0] b);
    bit seen;
    bit ok = 1'b0;
    rx_valid8 = 1'b1;
    rx_data8  = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); seen = rx_ready8;
      @(posedge clk); #1;
      ok = seen;
    end
    if (!ok) chk("rx_accept_timeout8", 32'd0, 32'd1);
  endtask

  task automatic txn32(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] sum, input bit gaps);
    exp_en32.push_back(a);
    exp_en32.push_back(b);
    for (int k = 0; k < 4; k++) exp_tx32.push_back(sum[8*k +: 8]);
    for (int k = 0; k < 4; k++) send32(a[8*k +: 8], gaps);
    for (int k = 0; k < 4; k++) send32(b[8*k +: 8], gaps);
    rx_valid32 = 1'b0;
    @(negedge clk);
    chk("rx_ready_after_b", 32'(rx_ready32), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic drain32();
    for (int i = 0; i < 1000 && exp_tx32.size() != 0; i++) begin @(posedge clk); #1; end
    chk("drain32", 32'(exp_tx32.size()), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    chk("rx_ready_after_tx", 32'(rx_ready32), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_add_en"},   32'(add_en32),   32'd0);
    chk({tag, "_add_x"},    add_x32,         32'd0);
    chk({tag, "_tx_valid"}, 32'(tx_valid32), 32'd0);
    chk({tag, "_tx_data"},  32'(tx_data32),  32'd0);
    chk({tag, "_rx_ready"}, 32'(rx_ready32), 32'd1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int en_start;
    resetn = 1'b0;
    rx_valid32 = 1'b0; rx_data32 = 8'h00;
    rx_valid8 = 1'b0;  rx_data8 = 8'h00; tx_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset32");
    chk("reset8_add_en", 32'(add_en8), 32'd0);
    chk("reset8_rx_ready", 32'(rx_ready8), 32'd1);
    resetn = 1'b1;

    txn32(32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0);
    drain32();
    txn32(32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0);
    drain32();

    bp_mode = 1'b1;
    en_start = en_cnt32;
    txn32(32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0);
    drain32();
    chk("bp_en_pulses", 32'(en_cnt32 - en_start), 32'd2);
    bp_mode = 1'b0;

    en_start = en_cnt32;
    txn32(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b1);
    drain32();
    chk("gap_en_pulses", 32'(en_cnt32 - en_start), 32'd2);

    // Abort after A and two bytes of B; nothing may be emitted for it.
    exp_en32.push_back(32'h0000_0099);
    send32(8'h99, 1'b0); send32(8'h00, 1'b0); send32(8'h00, 1'b0); send32(8'h00, 1'b0);
    send32(8'h11, 1'b0); send32(8'h22, 1'b0);
    rx_valid32 = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("midreset");
    resetn = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("midreset_no_tx", 32'(tx_valid32), 32'd0);
    txn32(32'h0000_000A, 32'h0000_000B, 32'h0000_0015, 1'b0);
    drain32();

    exp_en8.push_back(8'h80);
    exp_en8.push_back(8'h90);
    exp_tx8.push_back(8'h10);
    send8(8'h80);
    send8(8'h90);
    rx_valid8 = 1'b0;
    for (int i = 0; i < 100 && exp_tx8.size() != 0; i++) begin @(posedge clk); #1; end
    repeat (2) begin @(posedge clk); #1; end
    chk("w8_drain", 32'(exp_tx8.size()), 32'd0);
    chk("w8_back_to_back_en", 32'(b2b8), 32'd1);
    chk("w8_rx_ready_after", 32'(rx_ready8), 32'd1);

    chk("en32_queue_empty", 32'(exp_en32.size()), 32'd0);
    chk("en8_queue_empty", 32'(exp_en8.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
